// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-network front end.
// The encoder and its channel slices import this package.
package snn_pkg;

  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_VALUE_WIDTH = 8;
  localparam int DEFAULT_TIMESTEPS   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_e;

endpackage

// File: rtl/spike_encoder_channel.sv
// One encoder lane: stores sign/magnitude of a value and emits rate-coded spikes
// by accumulating the magnitude against a half-range threshold each step.
module spike_encoder_channel
  import snn_pkg::*;
#(
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic                          commit_i,
  input  logic                          active_i,
  input  logic signed [VALUE_WIDTH-1:0] value_i,
  output logic                          pos_spike_o,
  output logic                          neg_spike_o
);

  localparam int            AW = VALUE_WIDTH + 1;
  localparam logic [AW-1:0] TH = AW'(1) << (VALUE_WIDTH - 1);

  logic                   sign_q, sign_d;
  logic [VALUE_WIDTH-1:0] mag_q, mag_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [AW-1:0]          sum;
  logic                   fire;

  // acc stays below TH, so acc + |v| always fits in VALUE_WIDTH+1 bits.
  assign sum  = acc_q + {1'b0, mag_q};
  assign fire = (sum >= TH);

  // NOTE: every next-state variable gets its hold value first so no path infers a latch.
  always_comb begin
    sign_d = sign_q;
    mag_d  = mag_q;
    acc_d  = acc_q;
    if (load_i) begin
      sign_d = value_i[VALUE_WIDTH-1];
      mag_d  = value_i[VALUE_WIDTH-1] ? $unsigned(-value_i) : $unsigned(value_i);
      acc_d  = '0;
    end else if (commit_i) begin
      acc_d = fire ? (sum - TH) : sum;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      acc_q  <= '0;
    end else begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
      acc_q  <= acc_d;
    end
  end

  // fire implies a non-zero magnitude, so the sign alone selects the polarity.
  assign pos_spike_o = active_i && fire && !sign_q;
  assign neg_spike_o = active_i && fire &&  sign_q;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: accepts a signed vector in IDLE, then streams
// TIMESTEPS spike steps with a valid/ready handshake and pulses done at the end.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int TIMESTEPS   = DEFAULT_TIMESTEPS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [VALUE_WIDTH-1:0] in_values [CHANNELS],
  output logic [CHANNELS-1:0]           positive_spike,
  output logic [CHANNELS-1:0]           negative_spike,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [$clog2(TIMESTEPS)-1:0]  step_index,
  output logic                          done
);

  localparam int            SW   = $clog2(TIMESTEPS);
  localparam logic [SW-1:0] LAST = SW'(TIMESTEPS - 1);

  enc_state_e    state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic          done_q, done_d;
  logic          accept;
  logic          advance;

  assign in_ready    = (state_q == IDLE);
  assign spike_valid = (state_q == RUN);
  assign accept      = in_valid && in_ready;
  assign advance     = spike_valid && spike_ready;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          step_d  = '0;
        end
      end
      RUN: begin
        if (advance) begin
          if (step_q == LAST) begin
            state_d = IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign step_index = step_q;
  assign done       = done_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    spike_encoder_channel #(
      .VALUE_WIDTH(VALUE_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (accept),
      .commit_i   (advance),
      .active_i   (spike_valid),
      .value_i    (in_values[i]),
      .pos_spike_o(positive_spike[i]),
      .neg_spike_o(negative_spike[i])
    );
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed and randomized checks of spike_encoder against a rate-coding reference:
// a channel of magnitude m has fired floor(n*m/TH) times after n steps.
module tb_spike_encoder;

  localparam int CH = 4;
  localparam int VW = 8;
  localparam int TS = 16;
  localparam int TH = 128;
  localparam int SW = 4;

  typedef logic signed [VW-1:0] vec_t [CH];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  vec_t          in_values = '{default: '0};
  logic [CH-1:0] positive_spike;
  logic [CH-1:0] negative_spike;
  logic          spike_valid;
  logic          spike_ready = 1'b0;
  logic [SW-1:0] step_index;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_encoder #(
    .CHANNELS   (CH),
    .VALUE_WIDTH(VW),
    .TIMESTEPS  (TS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_values     (in_values),
    .positive_spike(positive_spike),
    .negative_spike(negative_spike),
    .spike_valid   (spike_valid),
    .spike_ready   (spike_ready),
    .step_index    (step_index),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mag(input logic signed [VW-1:0] v);
    int x;
    x = int'(v);
    return (x < 0) ? -x : x;
  endfunction

  // Spike on step k exactly when the running count floor(n*m/TH) rises.
  function automatic bit fires(input logic signed [VW-1:0] v, input int k);
    int m;
    m = mag(v);
    return (((k + 1) * m) / TH) != ((k * m) / TH);
  endfunction

  function automatic logic [CH-1:0] exp_pos(input vec_t vals, input int k);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (vals[c] > 0) && fires(vals[c], k);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_neg(input vec_t vals, input int k);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (vals[c] < 0) && fires(vals[c], k);
    return r;
  endfunction

  task automatic rand_vec(output vec_t v);
    for (int c = 0; c < CH; c++) v[c] = VW'($urandom());
  endtask

  // Presents vals and waits (bounded) for the accepting edge.
  task automatic start(input vec_t vals);
    int w;
    w = 0;
    in_values = vals;
    in_valid  = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Streams one encoded vector. mode: 0 ready held, 1 ready toggling, 2 random.
  // hold keeps in_valid high with nxt presented; abort_at pulses reset at that step.
  task automatic run(input vec_t vals, input int mode, input bit hold,
                     input vec_t nxt, input int abort_at);
    int            k;
    int            cyc;
    int            cp [CH];
    int            cn [CH];
    bit            rdy;
    logic [CH-1:0] sp, sn;
    vec_t          junk;
    k   = 0;
    cyc = 0;
    for (int c = 0; c < CH; c++) begin
      cp[c] = 0;
      cn[c] = 0;
    end
    in_valid = hold;
    while (k < TS && cyc < 400) begin
      chk("spike_valid_run", 32'(spike_valid), 32'd1);
      chk("in_ready_run", 32'(in_ready), 32'd0);
      chk("done_run", 32'(done), 32'd0);
      chk("step_index", 32'(step_index), 32'(k));
      chk("positive_spike", 32'(positive_spike), 32'(exp_pos(vals, k)));
      chk("negative_spike", 32'(negative_spike), 32'(exp_neg(vals, k)));
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_spike_valid", 32'(spike_valid), 32'd0);
        chk("rst_positive", 32'(positive_spike), 32'd0);
        chk("rst_negative", 32'(negative_spike), 32'd0);
        chk("rst_step_index", 32'(step_index), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        return;
      end
      sp = positive_spike;
      sn = negative_spike;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      spike_ready = rdy;
      if (hold) in_values = nxt;
      else begin
        rand_vec(junk);
        in_values = junk;
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        for (int c = 0; c < CH; c++) begin
          cp[c] += int'(sp[c]);
          cn[c] += int'(sn[c]);
        end
        k++;
      end
    end
    chk("run_completed_steps", 32'(k), 32'(TS));
    chk("done_pulse", 32'(done), 32'd1);
    chk("spike_valid_idle", 32'(spike_valid), 32'd0);
    chk("positive_idle", 32'(positive_spike), 32'd0);
    chk("negative_idle", 32'(negative_spike), 32'd0);
    chk("in_ready_done", 32'(in_ready), 32'd1);
    chk("step_index_idle", 32'(step_index), 32'd0);
    for (int c = 0; c < CH; c++) begin
      chk("pos_count", 32'(cp[c]), 32'((vals[c] > 0) ? (TS * mag(vals[c])) / TH : 0));
      chk("neg_count", 32'(cn[c]), 32'((vals[c] < 0) ? (TS * mag(vals[c])) / TH : 0));
    end
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("spike_valid_after", 32'(spike_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t a, b, z, r;
    a = '{8'sd64, 8'sd0, -8'sd32, 8'sd127};
    b = '{-8'sd128, 8'sd127, 8'sd1, -8'sd1};
    z = '{default: '0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_spike_valid", 32'(spike_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_step_index", 32'(step_index), 32'd0);
    chk("reset_positive", 32'(positive_spike), 32'd0);
    chk("reset_negative", 32'(negative_spike), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Reference vector, ready held high
    start(a);
    run(a, 0, 1'b0, z, -1);
    idle_check();

    // Most-negative value spikes every step
    start(b);
    run(b, 0, 1'b0, z, -1);
    idle_check();

    // Ready toggling every cycle
    start(a);
    run(a, 1, 1'b0, z, -1);
    idle_check();

    // Reset in the middle of an encoding
    start(a);
    run(a, 0, 1'b0, z, 7);
    spike_ready = 1'b1;
    in_valid    = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_spike_valid", 32'(spike_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_release_done", 32'(done), 32'd0);
    chk("abort_release_ready", 32'(in_ready), 32'd1);
    start(b);
    run(b, 0, 1'b0, z, -1);
    idle_check();

    // in_valid held across two vectors: second accepted in the done cycle
    start(a);
    run(a, 0, 1'b1, b, -1);
    @(posedge clk); #1;
    run(b, 0, 1'b0, z, -1);
    idle_check();

    // Random vectors with random back-pressure
    repeat (6) begin
      rand_vec(r);
      start(r);
      run(r, 2, 1'b0, z, -1);
      idle_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning the number of encoded input channels.
REQ-002 SHALL have parameter VALUE_WIDTH, default 8, meaning the signed two's-complement width of each input value.
REQ-003 SHALL have parameter TIMESTEPS, default 16, meaning the spike steps per encoded vector; legal range is 2 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_values holds a vector to encode.
REQ-007 SHALL have port in_ready, output, 1 bit: encoder can accept a vector.
REQ-008 SHALL have port in_values, input, array [CHANNELS] of signed VALUE_WIDTH: values to encode.
REQ-009 SHALL have port positive_spike, output, array [CHANNELS] of 1 bit: positive spike per channel for the current step.
REQ-010 SHALL have port negative_spike, output, array [CHANNELS] of 1 bit: negative spike per channel for the current step.
REQ-011 SHALL have port spike_valid, output, 1 bit: the spike arrays hold a valid step.
REQ-012 SHALL have port spike_ready, input, 1 bit: downstream neuron layer consumes the step.
REQ-013 SHALL have port step_index, output, clog2(TIMESTEPS) bits: index of the current step, 0..TIMESTEPS-1.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the final step is consumed.

Function
REQ-015 SHALL implement states IDLE and RUN; reset enters IDLE.
REQ-016 SHALL assert in_ready only in IDLE; acceptance occurs when in_valid and in_ready are both high at a clock edge.
REQ-017 SHALL on acceptance register all in_values, split each into a sign bit and a magnitude |v| of VALUE_WIDTH bits, clear all accumulators, clear step_index, and enter RUN.
REQ-018 SHALL ignore in_values while in RUN.
REQ-019 SHALL hold threshold TH = 2^(VALUE_WIDTH-1) and a per-channel unsigned accumulator acc of VALUE_WIDTH+1 bits.
REQ-020 SHALL for step k compute s = acc + |v| per channel; spike when s >= TH, with the next acc = s - TH, otherwise the next acc = s.
REQ-021 SHALL route a spike to positive_spike when v > 0 and to negative_spike when v < 0; both SHALL never be high together.
REQ-022 SHALL produce no spikes for v = 0; v = -2^(VALUE_WIDTH-1) SHALL spike negatively on every step.
REQ-023 SHALL assert spike_valid throughout RUN, with the first step presented the cycle after acceptance (latency 1).
REQ-024 SHALL hold spike outputs, step_index and acc stable while spike_valid=1 and spike_ready=0.
REQ-025 SHALL on a spike_valid and spike_ready handshake commit acc and increment step_index; when step_index = TIMESTEPS-1 it SHALL instead return to IDLE and pulse done for exactly one cycle.
REQ-026 SHALL drive positive_spike and negative_spike to all zeros whenever spike_valid=0.
REQ-027 SHALL allow the next acceptance in the cycle done is high, because IDLE is already active.

Reset
REQ-028 SHALL on rst_n low asynchronously force IDLE, in_ready=1 once released, and spike_valid=0, done=0, step_index=0, all spikes 0, all accumulators 0, all stored values 0.
REQ-029 SHALL abort any encoding in progress on reset with no done pulse.

Structure
REQ-030 SHALL place the state enum and the default VALUE_WIDTH/TIMESTEPS constants in shared package snn_pkg.
REQ-031 SHALL instantiate one sub-module spike_encoder_channel per channel, holding the stored value, acc and spike generation; the top holds the FSM and handshakes.

Verification
REQ-032 SHALL cover VALUE_WIDTH=8, TIMESTEPS=16, in_values={64,0,-32,127} with spike_ready held 1: this SHALL give counts of 8 positive, 0, 4 negative and 15 positive, with ch0 spiking on odd steps.
REQ-033 SHALL cover in_values={-128,...} producing a negative spike on all 16 steps and done exactly one cycle after step 15.
REQ-034 SHALL cover spike_ready toggling 0/1 every cycle: the spike counts SHALL match REQ-032 and outputs SHALL stay stable while stalled.
REQ-035 SHALL cover rst_n pulsed low at step 7: outputs clear immediately, no done pulse occurs, and the following vector encodes from step 0.
REQ-036 SHALL cover in_valid held high across two vectors: the second is accepted in the done cycle, in_ready=0 during RUN, and the first spike_valid appears one cycle after acceptance.
